// File: rtl/frame_anim_ctrl_pkg.sv
// Shared definitions for the frame animation controller: FSM encoding, switch bit map
// and the wrap-around scroll step used by the top level.
package frame_anim_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } anim_state_t;

  localparam int UI_SPEED_LSB = 0;
  localparam int UI_SPEED_MSB = 3;
  localparam int UI_DIR       = 4;
  localparam int UI_PAUSE     = 5;
  localparam int UI_STEP      = 6;
  localparam int UI_W         = 7;

  // Scene is 10 bars x 40 px, so one full scroll cycle is 400 px.
  localparam int PERIOD_DEFAULT     = 400;
  localparam int DEB_FRAMES_DEFAULT = 2;

  // Accepted word after reset: speed=4, forward, running, no step.
  localparam logic [UI_W-1:0] UI_RESET_WORD = 7'b000_0100;

  // One scroll step with exact wrap; x is always below period on entry.
  function automatic logic [9:0] wrap_step(input logic [9:0]  x,
                                           input logic [3:0]  s,
                                           input logic        rev,
                                           input logic [10:0] period);
    logic [10:0] xs;
    logic [10:0] ss;
    logic [10:0] t;
    xs = {1'b0, x};
    ss = {7'b0, s};
    if (rev) begin
      t = (xs < ss) ? (xs + period - ss) : (xs - ss);
    end else begin
      t = xs + ss;
      if (t >= period) t = t - period;
    end
    return t[9:0];
  endfunction

endpackage

// File: rtl/frame_anim_ctrl_if.sv
// Control/status bundle between the animation controller and its environment.
interface frame_anim_ctrl_if;
  logic       vsync_in;
  logic [7:0] ui_in;
  logic       frame_tick;
  logic [9:0] x_offset;
  logic       started;
  logic       paused;
  logic [3:0] speed_eff;

  modport master (
    output vsync_in, ui_in,
    input  frame_tick, x_offset, started, paused, speed_eff
  );

  modport slave (
    input  vsync_in, ui_in,
    output frame_tick, x_offset, started, paused, speed_eff
  );
endinterface

// File: rtl/frame_anim_ctrl_ui_debounce.sv
// Switch conditioning: 2-flop synchroniser, frame-rate debounce of the whole word and
// rising-edge detection of the accepted step bit.
module frame_anim_ctrl_ui_debounce
  import frame_anim_ctrl_pkg::*;
#(
  parameter int DEB_FRAMES = DEB_FRAMES_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [UI_W-1:0] ui_raw,
  input  logic            frame_tick,
  input  logic            step_clr,
  output logic [UI_W-1:0] word_now,
  output logic            step_pulse
);

  localparam logic [2:0] DEB_MAX = 3'(DEB_FRAMES);

  logic [UI_W-1:0] sync_word;

  for (genvar gi = 0; gi < UI_W; gi++) begin : g_sync
    logic s1_reg;
    logic s2_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_reg <= 1'b0;
        s2_reg <= 1'b0;
      end else begin
        s1_reg <= ui_raw[gi];
        s2_reg <= s1_reg;
      end
    end
    assign sync_word[gi] = s2_reg;
  end

  logic [UI_W-1:0] cand_reg;
  logic [UI_W-1:0] acc_reg;
  logic [2:0]      cnt_reg;
  logic            step_pulse_reg;
  logic [2:0]      cnt_next;
  logic            accept;
  logic            step_rise;

  assign cnt_next  = (sync_word != cand_reg) ? 3'd1 :
                     (cnt_reg == DEB_MAX)    ? cnt_reg : cnt_reg + 3'd1;
  assign accept    = frame_tick & (cnt_next == DEB_MAX);
  assign step_rise = accept & sync_word[UI_STEP] & ~acc_reg[UI_STEP];

  // The FSM acts on a word on the very tick it becomes accepted.
  assign word_now   = accept ? sync_word : acc_reg;
  assign step_pulse = step_pulse_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_reg       <= '0;
      cnt_reg        <= '0;
      acc_reg        <= UI_RESET_WORD;
      step_pulse_reg <= 1'b0;
    end else if (frame_tick) begin
      cand_reg <= sync_word;
      cnt_reg  <= cnt_next;
      if (accept) acc_reg <= sync_word;
      // A clear from the FSM beats a simultaneous new edge: a step seen in RUN is dropped.
      if (step_clr)       step_pulse_reg <= 1'b0;
      else if (step_rise) step_pulse_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/frame_anim_ctrl.sv
// Per-frame animation controller: vsync edge to frame tick, INIT/RUN/PAUSE FSM with
// single-frame step, and the wrapping x_offset scroll position.
module frame_anim_ctrl
  import frame_anim_ctrl_pkg::*;
#(
  parameter int PERIOD     = PERIOD_DEFAULT,
  parameter int DEB_FRAMES = DEB_FRAMES_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  frame_anim_ctrl_if.slave bus
);

  logic vsync_d_reg;
  logic armed_reg;
  logic frame_tick_reg;
  logic rise;

  // armed_reg blocks a tick when vsync is already high as reset is released.
  assign rise = bus.vsync_in & ~vsync_d_reg & armed_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d_reg    <= 1'b0;
      armed_reg      <= 1'b0;
      frame_tick_reg <= 1'b0;
    end else begin
      vsync_d_reg    <= bus.vsync_in;
      armed_reg      <= armed_reg | ~bus.vsync_in;
      frame_tick_reg <= rise;
    end
  end

  logic [UI_W-1:0] ui_word;
  logic            step_pulse;
  logic            step_clr;
  logic            unused_ui;

  assign unused_ui = bus.ui_in[7];

  frame_anim_ctrl_ui_debounce #(
    .DEB_FRAMES (DEB_FRAMES)
  ) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .ui_raw     (bus.ui_in[UI_W-1:0]),
    .frame_tick (frame_tick_reg),
    .step_clr   (step_clr),
    .word_now   (ui_word),
    .step_pulse (step_pulse)
  );

  anim_state_t state_reg;
  logic [9:0]  x_reg;
  logic        started_reg;
  logic        paused_reg;
  logic [3:0]  speed_eff_reg;
  logic [3:0]  speed_now;
  logic        pause_now;
  logic [9:0]  x_next;

  assign speed_now = (ui_word[UI_SPEED_MSB:UI_SPEED_LSB] == 4'd0) ? 4'd1
                                                                  : ui_word[UI_SPEED_MSB:UI_SPEED_LSB];
  assign pause_now = ui_word[UI_PAUSE];
  assign x_next    = wrap_step(x_reg, speed_now, ui_word[UI_DIR], 11'(PERIOD));
  assign step_clr  = frame_tick_reg &
                     ((state_reg == ST_RUN) ||
                      ((state_reg == ST_PAUSE) && pause_now && step_pulse));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_INIT;
      x_reg         <= '0;
      started_reg   <= 1'b0;
      paused_reg    <= 1'b0;
      speed_eff_reg <= 4'd4;
    end else if (frame_tick_reg) begin
      speed_eff_reg <= speed_now;
      case (state_reg)
        ST_INIT: begin
          started_reg <= 1'b1;
          state_reg   <= pause_now ? ST_PAUSE : ST_RUN;
          paused_reg  <= pause_now;
        end
        ST_RUN: begin
          if (pause_now) begin
            state_reg  <= ST_PAUSE;
            paused_reg <= 1'b1;
          end else begin
            x_reg <= x_next;
          end
        end
        ST_PAUSE: begin
          if (!pause_now) begin
            state_reg  <= ST_RUN;
            paused_reg <= 1'b0;
          end else if (step_pulse) begin
            x_reg <= x_next;
          end
        end
        default: begin
          state_reg  <= ST_INIT;
          paused_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.frame_tick = frame_tick_reg;
  assign bus.x_offset   = x_reg;
  assign bus.started    = started_reg;
  assign bus.paused     = paused_reg;
  assign bus.speed_eff  = speed_eff_reg;

endmodule
